mainfsm: RTL and testbench

Multicycle control FSM for the RV32I core: sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives datapath enables and mux selects. It sits directly upstream of `aludec` and supplies its `ALUOp`. `aludec` combines `ALUOp` with `funct3`/`funct7b5`/`opb5` to form `ALUControl`. Outputs are Moore (state-decoded), except `PCWrite`.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/mainfsm.sv | 132 +++++++++++++
 tb/tb_mainfsm.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states,
// opcodes and the mux-select / ALU-op encodings seen by aludec and the datapath.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// Multicycle RV32I main controller: steps each instruction through fetch,
// decode, execute, memory and writeback, driving datapath enables and selects.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC + 4
// DECODE   | read registers, OldPC + imm for branch/jal target
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | read data memory
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to memory
// EXECR    | R-type ALU op
// EXECI    | I-type ALU op
// ALUWB    | write ALU result to rd
// JAL      | PC <= target, OldPC + 4 for link
// BEQ      | rs1 - rs2, branch on zero
module mainfsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       IllegalOp
);

    state_t state_q, state_d;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            // MEMWB, MEMWRITE, ALUWB, BEQ and the unused codes all return to fetch
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUOp     = ALUOP_ADD;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        IllegalOp = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: IllegalOp = 1'b0;
                    default:                                  IllegalOp = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite = pc_update | (branch & zero);

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: per-cycle expected output vectors for each
// instruction class, plus reset-abort and combinational-branch sequences.
module tb_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, IllegalOp;

    mainfsm dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, IllegalOp}
    typedef logic [13:0] outs_t;

    typedef struct {
        logic [6:0] op;
        logic       zero;
        outs_t      exp;
        string      name;
    } vec_t;

    vec_t  vecs[$];
    outs_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic outs_t mk(input logic [1:0] aop, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [1:0] rs,
                                 input logic adr, input logic ir, input logic rw,
                                 input logic mw, input logic pcw, input logic ill);
        return {aop, sa, sb, rs, adr, ir, rw, mw, pcw, ill};
    endfunction

    function automatic outs_t dut_outs();
        return {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
                RegWrite, MemWrite, PCWrite, IllegalOp};
    endfunction

    outs_t E_FETCH, E_DECODE, E_ILLDEC, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE;
    outs_t E_EXECR, E_EXECI, E_ALUWB, E_JAL, E_BEQ_Z, E_BEQ_NZ;

    task automatic compare(input string name);
        outs_t got, want;
        got  = dut_outs();
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, got);
        end else begin
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got %b want %b", name, got, want);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Called just after a falling edge; leaves the bench at the next falling edge.
    task automatic step(input logic [6:0] o, input logic z, input outs_t e, input string name);
        op   = o;
        zero = z;
        exp_q.push_back(e);
        #2;
        compare(name);
        @(negedge clk);
    endtask

    task automatic add(input logic [6:0] o, input logic z, input outs_t e, input string name);
        vec_t v;
        v.op = o; v.zero = z; v.exp = e; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        E_FETCH    = mk(2'b00, 2'b00, 2'b10, 2'b10, 0, 1, 0, 0, 1, 0);
        E_DECODE   = mk(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        E_ILLDEC   = mk(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1);
        E_MEMADR   = mk(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        E_MEMREAD  = mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
        E_MEMWB    = mk(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0);
        E_MEMWRITE = mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0);
        E_EXECR    = mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        E_EXECI    = mk(2'b10, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        E_ALUWB    = mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
        E_JAL      = mk(2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0);
        E_BEQ_Z    = mk(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        E_BEQ_NZ   = mk(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // lw: 5 cycles
        add(7'b0000011, 0, E_FETCH,   "lw_fetch");
        add(7'b0000011, 0, E_DECODE,  "lw_decode");
        add(7'b0000011, 0, E_MEMADR,  "lw_memadr");
        add(7'b0000011, 0, E_MEMREAD, "lw_memread");
        add(7'b0000011, 0, E_MEMWB,   "lw_memwb");
        // sw: 4 cycles
        add(7'b0100011, 1, E_FETCH,    "sw_fetch");
        add(7'b0100011, 1, E_DECODE,   "sw_decode");
        add(7'b0100011, 1, E_MEMADR,   "sw_memadr");
        add(7'b0100011, 1, E_MEMWRITE, "sw_memwrite");
        // R-type
        add(7'b0110011, 0, E_FETCH,  "r_fetch");
        add(7'b0110011, 0, E_DECODE, "r_decode");
        add(7'b0110011, 0, E_EXECR,  "r_execr");
        add(7'b0110011, 0, E_ALUWB,  "r_aluwb");
        // I-type ALU
        add(7'b0010011, 1, E_FETCH,  "i_fetch");
        add(7'b0010011, 1, E_DECODE, "i_decode");
        add(7'b0010011, 1, E_EXECI,  "i_execi");
        add(7'b0010011, 1, E_ALUWB,  "i_aluwb");
        // jal
        add(7'b1101111, 0, E_FETCH,  "jal_fetch");
        add(7'b1101111, 0, E_DECODE, "jal_decode");
        add(7'b1101111, 0, E_JAL,    "jal_jal");
        add(7'b1101111, 0, E_ALUWB,  "jal_aluwb");
        // beq taken / not taken
        add(7'b1100011, 1, E_FETCH,  "beqt_fetch");
        add(7'b1100011, 1, E_DECODE, "beqt_decode");
        add(7'b1100011, 1, E_BEQ_Z,  "beqt_beq");
        add(7'b1100011, 0, E_FETCH,  "beqn_fetch");
        add(7'b1100011, 0, E_DECODE, "beqn_decode");
        add(7'b1100011, 0, E_BEQ_NZ, "beqn_beq");
        // illegal opcodes: 2 cycles
        add(7'b0000000, 0, E_FETCH,  "ill0_fetch");
        add(7'b0000000, 0, E_ILLDEC, "ill0_decode");
        add(7'b1111111, 1, E_FETCH,  "ill1_fetch");
        add(7'b1111111, 1, E_ILLDEC, "ill1_decode");
        // lw opcode with a flipped bit is not a load
        add(7'b0000111, 0, E_FETCH,  "ill2_fetch");
        add(7'b0000111, 0, E_ILLDEC, "ill2_decode");
        add(7'b0000011, 0, E_FETCH,  "tail_fetch");

        reset = 1'b1;
        op    = 7'b0;
        zero  = 1'b0;
        #2;
        exp_q.push_back(E_FETCH);
        compare("reset_hold");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i].op, vecs[i].zero, vecs[i].exp, vecs[i].name);
        // tail_fetch left the FSM in DECODE with op=lw; finish that lw
        step(7'b0000011, 0, E_DECODE,  "post_decode");
        step(7'b0000011, 0, E_MEMADR,  "post_memadr");
        step(7'b0000011, 0, E_MEMREAD, "post_memread");
        step(7'b0000011, 0, E_MEMWB,   "post_memwb");

        // Reset mid-cycle during MEMWRITE
        step(7'b0100011, 0, E_FETCH,  "rst_sw_fetch");
        step(7'b0100011, 0, E_DECODE, "rst_sw_decode");
        step(7'b0100011, 0, E_MEMADR, "rst_sw_memadr");
        exp_q.push_back(E_MEMWRITE);
        #2;
        compare("rst_sw_memwrite");
        reset = 1'b1;
        #1;
        check_bit("rst_memwrite_drop", MemWrite, 1'b0);
        check_bit("rst_irwrite", IRWrite, 1'b1);
        check_bit("rst_pcwrite", PCWrite, 1'b1);
        exp_q.push_back(E_FETCH);
        compare("rst_async_fetch");
        @(negedge clk);
        exp_q.push_back(E_FETCH);
        #2;
        compare("rst_held_over_edge");
        @(negedge clk);
        reset = 1'b0;
        step(7'b0110011, 0, E_FETCH,  "rst_rel_fetch");
        step(7'b0110011, 0, E_DECODE, "rst_rel_decode");
        step(7'b0110011, 0, E_EXECR,  "rst_rel_execr");

        // Reset mid-cycle during ALUWB drops RegWrite
        exp_q.push_back(E_ALUWB);
        #2;
        compare("rst2_aluwb");
        reset = 1'b1;
        #1;
        check_bit("rst2_regwrite_drop", RegWrite, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(7'b1100011, 0, E_FETCH,  "bz_fetch");
        step(7'b1100011, 0, E_DECODE, "bz_decode");

        // PCWrite follows zero combinationally within BEQ
        zero = 1'b0;
        #2;
        check_bit("beq_pcw_z0", PCWrite, 1'b0);
        zero = 1'b1;
        #1;
        check_bit("beq_pcw_z1", PCWrite, 1'b1);
        zero = 1'b0;
        #1;
        check_bit("beq_pcw_z0_again", PCWrite, 1'b0);
        @(negedge clk);
        step(7'b1100011, 0, E_FETCH, "bz_after_fetch");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
